// File: rtl/aes_pkg.sv
// Shared AES-128 arithmetic: GF(2^8) helpers, S-boxes, Rcon decode and the forward key step.
// Used by both the encryption and decryption engines.
package aes_pkg;

    localparam int NR = 10;
    localparam int BW = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        KEXP = 2'd1,
        DEC  = 2'd2
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            acc = acc ^ (b[i] ? p : 8'h00);
            p   = xtime(p);
        end
        return acc;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0), built from a square-and-multiply chain.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] t;
        t = gf_mul(gf_mul(x, x), x);          // x^3
        t = gf_mul(gf_mul(t, t), x);          // x^7
        t = gf_mul(gf_mul(t, t), x);          // x^15
        t = gf_mul(gf_mul(t, t), x);          // x^31
        t = gf_mul(gf_mul(t, t), x);          // x^63
        t = gf_mul(gf_mul(t, t), x);          // x^127
        return gf_mul(t, t);                  // x^254
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        logic [7:0] b;
        b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    function automatic logic [7:0] rcon_byte(input logic [NR-1:0] rc);
        logic [7:0] r;
        case (rc)
            10'b00_0000_0001: r = 8'h01;
            10'b00_0000_0010: r = 8'h02;
            10'b00_0000_0100: r = 8'h04;
            10'b00_0000_1000: r = 8'h08;
            10'b00_0001_0000: r = 8'h10;
            10'b00_0010_0000: r = 8'h20;
            10'b00_0100_0000: r = 8'h40;
            10'b00_1000_0000: r = 8'h80;
            10'b01_0000_0000: r = 8'h1b;
            10'b10_0000_0000: r = 8'h36;
            default:          r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [BW-1:0] key_fwd(input logic [BW-1:0] k, input logic [7:0] rcon);
        logic [31:0] n0;
        logic [31:0] n1;
        logic [31:0] n2;
        logic [31:0] n3;
        n0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rcon, 24'h000000};
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0]  ^ n2;
        return {n0, n1, n2, n3};
    endfunction

endpackage

// File: rtl/inv_round.sv
// One combinational AES inverse round plus the matching inverse key-schedule step.
// Byte i of the state is column i/4, row i%4, at bits [127-8i -: 8].
module inv_round
    import aes_pkg::*;
(
    input  logic [BW-1:0] st,
    input  logic [BW-1:0] rk_cur,
    input  logic [NR-1:0] rc,
    input  logic          last,
    output logic [BW-1:0] st_next,
    output logic [BW-1:0] rk_prev
);

    logic [31:0]   w3p_s;
    logic [31:0]   w2p_s;
    logic [31:0]   w1p_s;
    logic [31:0]   w0p_s;
    logic [BW-1:0] sr_s;
    logic [BW-1:0] ak_s;
    logic [BW-1:0] mc_s;

    // Walk the key schedule back one round: recover round key i-1 from round key i.
    always_comb begin
        w3p_s   = rk_cur[31:0]  ^ rk_cur[63:32];
        w2p_s   = rk_cur[63:32] ^ rk_cur[95:64];
        w1p_s   = rk_cur[95:64] ^ rk_cur[127:96];
        w0p_s   = rk_cur[127:96] ^ sub_rot_word(w3p_s) ^ {rcon_byte(rc), 24'h000000};
        rk_prev = {w0p_s, w1p_s, w2p_s, w3p_s};
    end

    // InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns except on the final round.
    always_comb begin
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] a3;
        sr_s = {BW{1'b0}};
        mc_s = {BW{1'b0}};
        a0   = 8'h00;
        a1   = 8'h00;
        a2   = 8'h00;
        a3   = 8'h00;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr_s[127-8*(4*c+r) -: 8] = inv_sbox(st[127-8*(4*(((c-r)+4)%4)+r) -: 8]);
            end
        end
        ak_s = sr_s ^ rk_prev;
        for (int c = 0; c < 4; c++) begin
            a0 = ak_s[127-32*c -: 8];
            a1 = ak_s[119-32*c -: 8];
            a2 = ak_s[111-32*c -: 8];
            a3 = ak_s[103-32*c -: 8];
            mc_s[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            mc_s[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            mc_s[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            mc_s[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        st_next = last ? ak_s : mc_s;
    end

endmodule

// File: rtl/aes_dec_iter.sv
// Iterative AES-128 decryption engine, one inverse round per clock.
// The key is expanded forward once to K10; decryption walks the schedule back on the fly.
module aes_dec_iter
    import aes_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          krdy,
    input  logic [BW-1:0] kin,
    input  logic          drdy,
    input  logic [BW-1:0] din,
    output logic [BW-1:0] dout,
    output logic          kvld,
    output logic          dvld,
    output logic          bsy
);

    state_t        state_r;
    state_t        state_s;
    logic [BW-1:0] key_r;
    logic [BW-1:0] rk_r;
    logic [BW-1:0] st_r;
    logic [NR-1:0] rc_r;
    logic          kok_r;
    logic [BW-1:0] dout_r;
    logic          kvld_r;
    logic          dvld_r;
    logic          bsy_r;
    logic          load_key_s;
    logic          start_dec_s;
    logic          kexp_done_s;
    logic          dec_done_s;
    logic [BW-1:0] rnd_st_s;
    logic [BW-1:0] rnd_rk_s;

    inv_round u_inv_round (
        .st      (st_r),
        .rk_cur  (rk_r),
        .rc      (rc_r),
        .last    (rc_r[0]),
        .st_next (rnd_st_s),
        .rk_prev (rnd_rk_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state and control strobes; a key load takes priority over a decrypt request.
    always_comb begin
        state_s     = state_r;
        load_key_s  = 1'b0;
        start_dec_s = 1'b0;
        kexp_done_s = 1'b0;
        dec_done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (en && krdy) begin
                    load_key_s = 1'b1;
                    state_s    = KEXP;
                end else if (en && drdy && kok_r) begin
                    start_dec_s = 1'b1;
                    state_s     = DEC;
                end else begin
                    state_s = IDLE;
                end
            end
            KEXP: begin
                if (rc_r[NR-1]) begin
                    kexp_done_s = 1'b1;
                    state_s     = IDLE;
                end else begin
                    state_s = KEXP;
                end
            end
            DEC: begin
                if (rc_r[0]) begin
                    dec_done_s = 1'b1;
                    state_s    = IDLE;
                end else begin
                    state_s = DEC;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Key schedule, working round key and cipher state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_r <= {BW{1'b0}};
            rk_r  <= {BW{1'b0}};
            st_r  <= {BW{1'b0}};
            rc_r  <= {NR{1'b0}};
            kok_r <= 1'b0;
        end else if (load_key_s) begin
            key_r <= kin;
            rc_r  <= {{(NR-1){1'b0}}, 1'b1};
            kok_r <= 1'b0;
        end else if (state_r == KEXP) begin
            key_r <= key_fwd(key_r, rcon_byte(rc_r));
            rc_r  <= {rc_r[NR-2:0], 1'b0};
            kok_r <= kexp_done_s;
        end else if (start_dec_s) begin
            st_r <= din ^ key_r;
            rk_r <= key_r;
            rc_r <= {1'b1, {(NR-1){1'b0}}};
        end else if (state_r == DEC) begin
            st_r <= rnd_st_s;
            // Restore K10 on the last round so the next block starts from it.
            rk_r <= dec_done_s ? key_r : rnd_rk_s;
            rc_r <= {1'b0, rc_r[NR-1:1]};
        end
    end

    // Registered host-facing outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_r <= {BW{1'b0}};
            kvld_r <= 1'b0;
            dvld_r <= 1'b0;
            bsy_r  <= 1'b0;
        end else begin
            kvld_r <= kexp_done_s;
            dvld_r <= dec_done_s;
            bsy_r  <= (state_s != IDLE);
            if (dec_done_s) begin
                dout_r <= rnd_st_s;
            end
        end
    end

    assign dout = dout_r;
    assign kvld = kvld_r;
    assign dvld = dvld_r;
    assign bsy  = bsy_r;

endmodule

// File: tb/tb_aes_dec_iter.sv
// Directed bench for aes_dec_iter using FIPS-197 vectors and handshake corner cases.
module tb_aes_dec_iter;

    logic         clk;
    logic         rst;
    logic         en;
    logic         krdy;
    logic [127:0] kin;
    logic         drdy;
    logic [127:0] din;
    logic [127:0] dout;
    logic         kvld;
    logic         dvld;
    logic         bsy;

    int n_chk;
    int n_fail;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K10_B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K10_C = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;

    aes_dec_iter dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .krdy (krdy),
        .kin  (kin),
        .drdy (drdy),
        .din  (din),
        .dout (dout),
        .kvld (kvld),
        .dvld (dvld),
        .bsy  (bsy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic load_key(input logic [127:0] k, input logic [127:0] k10, input logic with_drdy);
        kin  = k;
        krdy = 1'b1;
        drdy = with_drdy;
        din  = CT_C;
        tick();
        krdy = 1'b0;
        drdy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chkb("kexp_bsy", bsy, 1'b1);
            chkb("kexp_kvld_early", kvld, 1'b0);
            chkb("kexp_dvld", dvld, 1'b0);
            tick();
        end
        chkb("kvld_pulse", kvld, 1'b1);
        chkb("kvld_bsy_low", bsy, 1'b0);
        chkb("kvld_no_dvld", dvld, 1'b0);
        chk("k10", dut.key_r, k10);
    endtask

    task automatic decrypt(input logic [127:0] ct, input logic [127:0] pt,
                           input logic [127:0] prev, input int poke);
        din  = ct;
        drdy = 1'b1;
        tick();
        drdy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chkb("dec_bsy", bsy, 1'b1);
            chkb("dec_dvld_early", dvld, 1'b0);
            chk("dout_held", dout, prev);
            if (i == poke) begin
                drdy = 1'b1;
                krdy = 1'b1;
                din  = CT_B;
                kin  = KEY_B;
            end
            tick();
            drdy = 1'b0;
            krdy = 1'b0;
        end
        chkb("dvld_pulse", dvld, 1'b1);
        chkb("dvld_bsy_low", bsy, 1'b0);
        chk("plaintext", dout, pt);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst  = 1'b1;
        en   = 1'b1;
        krdy = 1'b0;
        drdy = 1'b0;
        kin  = 128'd0;
        din  = 128'd0;
        tick();
        tick();
        chk("rst_dout", dout, 128'd0);
        chkb("rst_kvld", kvld, 1'b0);
        chkb("rst_dvld", dvld, 1'b0);
        chkb("rst_bsy", bsy, 1'b0);
        rst = 1'b0;
        tick();

        // Decrypt request before any key has been loaded.
        din  = CT_B;
        drdy = 1'b1;
        tick();
        drdy = 1'b0;
        chkb("nokey_bsy", bsy, 1'b0);
        tick();
        chkb("nokey_dvld", dvld, 1'b0);

        // FIPS-197 Appendix B.
        load_key(KEY_B, K10_B, 1'b0);
        decrypt(CT_B, PT_B, 128'd0, -1);
        tick();
        chkb("dvld_one_cycle", dvld, 1'b0);
        chk("dout_hold_after", dout, PT_B);

        // en low blocks both key load and decrypt acceptance.
        en   = 1'b0;
        krdy = 1'b1;
        kin  = KEY_C;
        tick();
        krdy = 1'b0;
        chkb("en0_krdy_bsy", bsy, 1'b0);
        tick();
        chkb("en0_krdy_kvld", kvld, 1'b0);
        chk("en0_key_kept", dut.key_r, K10_B);
        drdy = 1'b1;
        tick();
        drdy = 1'b0;
        en   = 1'b1;
        chkb("en0_drdy_bsy", bsy, 1'b0);

        // Simultaneous krdy and drdy: key load wins, drdy dropped.
        load_key(KEY_C, K10_C, 1'b1);
        tick();
        chkb("both_no_dvld", dvld, 1'b0);
        chkb("both_idle", bsy, 1'b0);

        // FIPS-197 C.1 twice back to back, second with requests poked while busy.
        decrypt(CT_C, PT_C, PT_B, -1);
        decrypt(CT_C, PT_C, PT_C, 3);
        tick();
        chkb("poke_ignored_bsy", bsy, 1'b0);
        chkb("poke_ignored_kvld", kvld, 1'b0);
        chkb("poke_ignored_dvld", dvld, 1'b0);
        chk("poke_key_kept", dut.key_r, K10_C);

        // Reset in the middle of a decrypt.
        din  = CT_C;
        drdy = 1'b1;
        tick();
        drdy = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chkb("mid_bsy", bsy, 1'b1);
        rst = 1'b1;
        #1;
        chk("midrst_dout", dout, 128'd0);
        chkb("midrst_kvld", kvld, 1'b0);
        chkb("midrst_dvld", dvld, 1'b0);
        chkb("midrst_bsy", bsy, 1'b0);
        tick();
        rst  = 1'b0;
        din  = CT_C;
        drdy = 1'b1;
        tick();
        drdy = 1'b0;
        chkb("postrst_drdy_bsy", bsy, 1'b0);
        tick();
        chkb("postrst_drdy_dvld", dvld, 1'b0);

        load_key(KEY_C, K10_C, 1'b0);
        decrypt(CT_C, PT_C, 128'd0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
